simd_sub_wb: RTL and testbench
==============================

Name: simd_sub_wb

Overview:
- Writeback stage directly downstream of the lane-partitioned 16-bit SIMD subtractor (sub = dataA − dataB; bitnum selects lane width).
- Captures each subtract result with its operands and destination tag, and computes per-lane zero/negative/borrow/overflow flags.
- Buffers entries in a small FIFO and presents them to register-file writeback over a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- TAGW, 3, destination register tag width

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  result/operands valid this cycle
- in_ready  output  1  stage can accept
- dataA  input  16  minuend, as presented to the subtractor
- dataB  input  16  subtrahend, as presented to the subtractor
- bitnum  input  2  lane mode: 00=4×4b, 01/11=2×8b, 10=1×16b
- sub_res  input  16  subtractor output for the same cycle
- in_dst  input  TAGW  destination tag
- wb_valid  output  1  head entry valid
- wb_ready  input  1  writeback consumer accepts
- wb_data  output  16  result
- wb_dst  output  TAGW  tag
- wb_zero  output  4  per-lane result==0
- wb_neg  output  4  per-lane result MSB
- wb_borrow  output  4  per-lane unsigned A<B
- wb_ovf  output  4  per-lane signed overflow
- count  output  log2(DEPTH)+1  occupancy

Behaviour:
- Reset: all outputs 0 except in_ready=1. FIFO is emptied; count=0; wb_valid=0.
- Reset mid-operation discards all buffered entries. There is no partial writeback.
- Flag lane mapping:
  - bitnum 00: flag bit i ↔ nibble i.
  - bitnum 01/11: bit0 ↔ bits 7:0, bit1 ↔ bits 15:8; bits 3:2 = 0.
  - bitnum 10: bit0 ↔ bits 15:0; bits 3:1 = 0.
- Per-lane flag definitions, with a, b, r the lane slices of dataA, dataB, and stored result:
  - zero = (r==0)
  - neg = r.msb
  - borrow = (a <u b)
  - ovf = (a.msb≠b.msb) & (r.msb≠a.msb)
- Flags are computed combinationally from the inputs and stored alongside data in the same FIFO entry.
- Push occurs when in_valid & in_ready. Pop occurs when wb_valid & wb_ready.
- Latency: an entry accepted in cycle N is visible on wb_* in cycle N+1 at the earliest. There is no combinational in→wb path.
- in_ready = (count < DEPTH) and depends only on registered state.
  - When full, in_ready=0 even if a pop occurs in the same cycle; no pass-through.
- Simultaneous push and pop when not full: count unchanged; ordering is preserved (strict FIFO).
- Pop when empty is impossible (wb_valid=0). in_valid while full is ignored; the upstream stage holds.
- wb_* outputs must hold stable while wb_valid=1 and wb_ready=0.
- wb_* contents are don't-care when wb_valid=0; the implementation drives 0.
- Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count saturates at neither end; it is driven only by legal push/pop.

Optional Feature:
- Macro SIMD_WB_SAT_EN.
- When defined: every lane whose borrow=1 has its stored result replaced by 0 (unsigned saturating subtract) before storage.
  - zero/neg flags are computed on the saturated value.
  - borrow and ovf still report the raw operand relation.
- When undefined: sub_res is stored unmodified (wrap-around).
- Ports and timing are identical in both builds.

Test Plan:
- Reset while holding 3 buffered entries → next cycle count=0, wb_valid=0, in_ready=1, all wb_* = 0.
- bitnum=00, A=0x1234, B=0x2211, sub_res=0xF023 → wb_data=0xF023, zero=0100, neg=1000, borrow=1000, ovf=0000.
  - With SIMD_WB_SAT_EN: wb_data=0x0023, zero=1100, neg=0000.
- bitnum=10, A=0x8000, B=0x0001, sub_res=0x7FFF → zero=0000, neg=0000, borrow=0000, ovf=0001.
- bitnum=01, A=0x0505, B=0x0505, sub_res=0x0000 → zero=0011, neg=0000, borrow=0000, ovf=0000.
  - Repeat with bitnum=11 → identical flags.
- Push 5 entries with wb_ready=0 (DEPTH=4) → in_ready drops after the 4th accept; 5th is held upstream; count=4.
  - Then wb_ready=1 with in_valid=1 → full cycle pops without pushing.
  - Subsequently push+pop in the same cycle with count constant at 3.
  - Tags emerge in order 0,1,2,3,4.
- Backpressure: toggle wb_ready randomly over 200 pushes → every accepted entry appears exactly once, in order, with wb_* stable while stalled.
  - Pointers wrap at least 40 times with no loss.

Source files
------------

// File: rtl/simd_sub_wb.sv
// simd_sub_wb: writeback stage behind the lane-partitioned 16-bit SIMD subtractor.
// Each accepted result is captured together with its destination tag and its
// per-lane zero/negative/borrow/overflow flags, then queued in a DEPTH-entry FIFO.
// The FIFO drains to register-file writeback over a valid/ready handshake.
//
// Optional build macro: SIMD_WB_SAT_EN
//   Defined   -> a lane whose borrow is set stores 0 (unsigned saturating
//                subtract). zero/neg follow the stored value, while borrow/ovf
//                follow the raw operands.
//   Undefined -> sub_res is stored unmodified (wrap-around).
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   upstream handshake (in_ready depends on state only)
//   dataA, dataB, bitnum  subtractor operands and lane mode
//                         (00 = 4x4b, 01/11 = 2x8b, 10 = 1x16b)
//   sub_res, in_dst       subtractor result and destination tag
//   wb_valid / wb_ready   writeback handshake
//   wb_data, wb_dst       head entry payload (0 when wb_valid=0)
//   wb_zero/neg/borrow/ovf  per-lane flags of the head entry
//   count                 FIFO occupancy
module simd_sub_wb #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              dataA,
  input  logic [15:0]              dataB,
  input  logic [1:0]               bitnum,
  input  logic [15:0]              sub_res,
  input  logic [TAGW-1:0]          in_dst,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [15:0]              wb_data,
  output logic [TAGW-1:0]          wb_dst,
  output logic [3:0]               wb_zero,
  output logic [3:0]               wb_neg,
  output logic [3:0]               wb_borrow,
  output logic [3:0]               wb_ovf,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [15:0]     data;
    logic [TAGW-1:0] dst;
    logic [3:0]      zero;
    logic [3:0]      neg;
    logic [3:0]      borrow;
    logic [3:0]      ovf;
  } wbEntryT;

  wbEntryT         mem [DEPTH];
  wbEntryT         inEntry;
  wbEntryT         headEntry;
  logic [PtrW-1:0] wrPtr;
  logic [PtrW-1:0] rdPtr;
  logic [CntW-1:0] countQ;
  logic [CntW-1:0] countNext;
  logic            inReadyQ;
  logic            wbValidQ;
  logic            doPush;
  logic            doPop;

  logic [15:0]     resStored;
  logic [3:0]      zeroC;
  logic [3:0]      negC;
  logic [3:0]      borrowC;
  logic [3:0]      ovfC;

  // Per-lane flags; borrow/ovf use the raw operands and raw result, zero/neg
  // use the value that will actually be stored.
  always_comb begin
    resStored = sub_res;
    zeroC     = '0;
    negC      = '0;
    borrowC   = '0;
    ovfC      = '0;
    case (bitnum)
      2'b00: begin
        for (int i = 0; i < 4; i++) begin
          borrowC[i] = (dataA[4*i +: 4] < dataB[4*i +: 4]);
          ovfC[i]    = (dataA[4*i+3] != dataB[4*i+3]) & (sub_res[4*i+3] != dataA[4*i+3]);
`ifdef SIMD_WB_SAT_EN
          if (borrowC[i]) resStored[4*i +: 4] = 4'h0;
`endif
        end
        for (int i = 0; i < 4; i++) begin
          zeroC[i] = (resStored[4*i +: 4] == 4'h0);
          negC[i]  = resStored[4*i+3];
        end
      end
      2'b10: begin
        borrowC[0] = (dataA < dataB);
        ovfC[0]    = (dataA[15] != dataB[15]) & (sub_res[15] != dataA[15]);
`ifdef SIMD_WB_SAT_EN
        if (borrowC[0]) resStored = 16'h0000;
`endif
        zeroC[0] = (resStored == 16'h0000);
        negC[0]  = resStored[15];
      end
      default: begin
        for (int i = 0; i < 2; i++) begin
          borrowC[i] = (dataA[8*i +: 8] < dataB[8*i +: 8]);
          ovfC[i]    = (dataA[8*i+7] != dataB[8*i+7]) & (sub_res[8*i+7] != dataA[8*i+7]);
`ifdef SIMD_WB_SAT_EN
          if (borrowC[i]) resStored[8*i +: 8] = 8'h00;
`endif
        end
        for (int i = 0; i < 2; i++) begin
          zeroC[i] = (resStored[8*i +: 8] == 8'h00);
          negC[i]  = resStored[8*i+7];
        end
      end
    endcase
  end

  always_comb begin
    inEntry.data   = resStored;
    inEntry.dst    = in_dst;
    inEntry.zero   = zeroC;
    inEntry.neg    = negC;
    inEntry.borrow = borrowC;
    inEntry.ovf    = ovfC;
  end

  // Handshakes use the registered ready/valid, so a full FIFO never accepts
  // even when it is popped in the same cycle.
  assign doPush = in_valid & inReadyQ;
  assign doPop  = wbValidQ & wb_ready;

  always_comb begin
    countNext = countQ;
    case ({doPush, doPop})
      2'b10:   countNext = countQ + CntW'(1);
      2'b01:   countNext = countQ - CntW'(1);
      default: countNext = countQ;
    endcase
  end

  // Control state: pointers, occupancy and the registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      countQ   <= '0;
      inReadyQ <= 1'b1;
      wbValidQ <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PtrW'(1);
      if (doPop)  rdPtr <= rdPtr + PtrW'(1);
      countQ   <= countNext;
      inReadyQ <= (countNext < CntW'(DEPTH));
      wbValidQ <= (countNext != '0);
    end
  end

  // Storage needs no reset: contents are only observed through wbValidQ.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= inEntry;
  end

  assign headEntry = wbValidQ ? mem[rdPtr] : '0;

  assign in_ready  = inReadyQ;
  assign wb_valid  = wbValidQ;
  assign count     = countQ;
  assign wb_data   = headEntry.data;
  assign wb_dst    = headEntry.dst;
  assign wb_zero   = headEntry.zero;
  assign wb_neg    = headEntry.neg;
  assign wb_borrow = headEntry.borrow;
  assign wb_ovf    = headEntry.ovf;

endmodule

// File: tb/tb_simd_sub_wb.sv
// tb_simd_sub_wb: self-checking bench for simd_sub_wb against a queue model.
module tb_simd_sub_wb;

  localparam int DEPTH = 4;
  localparam int TAGW  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       dataA;
  logic [15:0]       dataB;
  logic [1:0]        bitnum;
  logic [15:0]       sub_res;
  logic [TAGW-1:0]   in_dst;
  logic              wb_valid;
  logic              wb_ready;
  logic [15:0]       wb_data;
  logic [TAGW-1:0]   wb_dst;
  logic [3:0]        wb_zero;
  logic [3:0]        wb_neg;
  logic [3:0]        wb_borrow;
  logic [3:0]        wb_ovf;
  logic [2:0]        count;

  simd_sub_wb #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dataA(dataA), .dataB(dataB), .bitnum(bitnum), .sub_res(sub_res),
    .in_dst(in_dst), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_dst(wb_dst), .wb_zero(wb_zero), .wb_neg(wb_neg),
    .wb_borrow(wb_borrow), .wb_ovf(wb_ovf), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     d;
    logic [TAGW-1:0] dst;
    logic [3:0]      z;
    logic [3:0]      n;
    logic [3:0]      b;
    logic [3:0]      o;
  } expT;

  expT         q[$];
  int          popLog[$];
  int          checks   = 0;
  int          failures = 0;
  int          accepted = 0;
  logic        stallPrev = 1'b0;
  logic [39:0] snap;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference: lane width from bitnum, then plain shift/mask arithmetic per lane.
  function automatic expT model(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] r, input logic [1:0] bn,
                                input logic [TAGW-1:0] dst);
    expT e;
    int unsigned w, nl, mask, la, lb, lr, top;
    w    = (bn == 2'b00) ? 4 : (bn == 2'b10) ? 16 : 8;
    nl   = 16 / w;
    mask = (32'd1 << w) - 1;
    top  = w - 1;
    e.d = r; e.dst = dst; e.z = '0; e.n = '0; e.b = '0; e.o = '0;
    for (int i = 0; i < int'(nl); i++) begin
      la = (32'(a) >> (w * i)) & mask;
      lb = (32'(b) >> (w * i)) & mask;
      lr = (32'(r) >> (w * i)) & mask;
      e.b[i] = (la < lb);
      e.o[i] = (((la >> top) & 1) != ((lb >> top) & 1)) && (((lr >> top) & 1) != ((la >> top) & 1));
`ifdef SIMD_WB_SAT_EN
      if (e.b[i]) begin
        lr  = 0;
        e.d = e.d & ~16'(mask << (w * i));
      end
`endif
      e.z[i] = (lr == 0);
      e.n[i] = (((lr >> top) & 1) != 0);
    end
    return e;
  endfunction

  // True lane-wise difference, used to give most random vectors a real sub_res.
  function automatic logic [15:0] laneSub(input logic [15:0] a, input logic [15:0] b, input logic [1:0] bn);
    int unsigned w, mask, acc;
    w = (bn == 2'b00) ? 4 : (bn == 2'b10) ? 16 : 8;
    mask = (32'd1 << w) - 1;
    acc = 0;
    for (int i = 0; i < 16 / int'(w); i++)
      acc |= ((((32'(a) >> (w * i)) & mask) - ((32'(b) >> (w * i)) & mask)) & mask) << (w * i);
    return 16'(acc);
  endfunction

  task automatic checkOutputs();
    chk("count", 32'(count), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("wb_valid", 32'(wb_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("wb_data", 32'(wb_data), 32'(q[0].d));
      chk("wb_dst", 32'(wb_dst), 32'(q[0].dst));
      chk("wb_zero", 32'(wb_zero), 32'(q[0].z));
      chk("wb_neg", 32'(wb_neg), 32'(q[0].n));
      chk("wb_borrow", 32'(wb_borrow), 32'(q[0].b));
      chk("wb_ovf", 32'(wb_ovf), 32'(q[0].o));
    end else begin
      chk("idle_payload", 32'({wb_data, wb_dst, wb_zero, wb_neg, wb_borrow, wb_ovf}), 32'd0);
    end
    if (stallPrev) begin
      chk("hold_lo", {wb_data, wb_dst, wb_zero, wb_neg, wb_borrow[3:3]}, snap[39:8]);
      chk("hold_hi", 32'({wb_borrow[2:0], wb_ovf}), 32'(snap[6:0]));
    end
  endtask

  // One clock: drive, check current outputs, advance the model with the edge.
  task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] r, input logic [1:0] bn,
                      input logic [TAGW-1:0] dst, input logic wr);
    logic doPush, doPop;
    expT  e;
    in_valid = iv; dataA = a; dataB = b; sub_res = r; bitnum = bn; in_dst = dst; wb_ready = wr;
    checkOutputs();
    doPush = iv && (q.size() < DEPTH);
    doPop  = wr && (q.size() != 0);
    if (doPop) popLog.push_back(int'(wb_dst));
    e = model(a, b, r, bn, dst);
    stallPrev = (q.size() != 0) && !wr;
    snap = {wb_data, wb_dst, wb_zero, wb_neg, wb_borrow, wb_ovf, 1'b0};
    snap = {snap[39:8], 1'b0, snap[7:1]};
    @(posedge clk); #1;
    if (doPop) void'(q.pop_front());
    if (doPush) begin
      q.push_back(e);
      accepted++;
    end
  endtask

  task automatic idle(input logic wr);
    step(1'b0, 16'h0, 16'h0, 16'h0, 2'b00, '0, wr);
  endtask

  initial begin
    expT  e;
    logic iv, wr;
    logic [15:0] a, b, r;
    logic [1:0]  bn;
    int   cyc;

    rst = 1'b1; in_valid = 0; dataA = 0; dataB = 0; sub_res = 0; bitnum = 0; in_dst = 0; wb_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst = 1'b0;

    // Hand-computed vectors pin the model.
    e = model(16'h1234, 16'h2211, 16'hF023, 2'b00, 3'd0);
`ifdef SIMD_WB_SAT_EN
    chk("pin0_data", 32'(e.d), 32'h0023);
    chk("pin0_zn", 32'({e.z, e.n}), 32'b1100_0000);
`else
    chk("pin0_data", 32'(e.d), 32'hF023);
    chk("pin0_zn", 32'({e.z, e.n}), 32'b0100_1000);
`endif
    chk("pin0_bo", 32'({e.b, e.o}), 32'b1000_0000);
    e = model(16'h8000, 16'h0001, 16'h7FFF, 2'b10, 3'd0);
    chk("pin1_flags", 32'({e.z, e.n, e.b, e.o}), 32'h0001);
    e = model(16'h0505, 16'h0505, 16'h0000, 2'b01, 3'd0);
    chk("pin2_flags", 32'({e.z, e.n, e.b, e.o}), 32'h3000);
    e = model(16'h0505, 16'h0505, 16'h0000, 2'b11, 3'd0);
    chk("pin3_flags", 32'({e.z, e.n, e.b, e.o}), 32'h3000);

    // Same vectors through the DUT, with literal checks at the head.
    step(1'b1, 16'h1234, 16'h2211, 16'hF023, 2'b00, 3'd5, 1'b0);
`ifdef SIMD_WB_SAT_EN
    chk("dut0_data", 32'(wb_data), 32'h0023);
    chk("dut0_zero", 32'(wb_zero), 32'b1100);
    chk("dut0_neg", 32'(wb_neg), 32'b0000);
`else
    chk("dut0_data", 32'(wb_data), 32'hF023);
    chk("dut0_zero", 32'(wb_zero), 32'b0100);
    chk("dut0_neg", 32'(wb_neg), 32'b1000);
`endif
    chk("dut0_borrow", 32'(wb_borrow), 32'b1000);
    chk("dut0_ovf", 32'(wb_ovf), 32'b0000);
    step(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 2'b10, 3'd6, 1'b1);
    chk("dut1_flags", 32'({wb_zero, wb_neg, wb_borrow, wb_ovf}), 32'h0001);
    step(1'b1, 16'h0505, 16'h0505, 16'h0000, 2'b01, 3'd7, 1'b1);
    chk("dut2_flags", 32'({wb_zero, wb_neg, wb_borrow, wb_ovf}), 32'h3000);
    step(1'b1, 16'h0505, 16'h0505, 16'h0000, 2'b11, 3'd1, 1'b1);
    chk("dut3_flags", 32'({wb_zero, wb_neg, wb_borrow, wb_ovf}), 32'h3000);
    idle(1'b1);
    idle(1'b1);

    // Reset with three buffered entries.
    for (int t = 0; t < 3; t++) step(1'b1, 16'(t), 16'h1, 16'(t - 1), 2'b10, 3'(t), 1'b0);
    chk("pre_rst_count", 32'(count), 32'd3);
    in_valid = 1'b0; wb_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    stallPrev = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_valid", 32'(wb_valid), 32'd0);
    chk("mid_rst_payload", 32'({wb_data, wb_dst, wb_zero, wb_neg, wb_borrow, wb_ovf}), 32'd0);
    idle(1'b0);

    // Fill past full, pop from full, then steady push+pop at count 3.
    popLog.delete();
    for (int t = 0; t < 4; t++) step(1'b1, 16'h00F0, 16'h000F, 16'h00E1, 2'b01, 3'(t), 1'b0);
    chk("full_ready", 32'(in_ready), 32'd0);
    step(1'b1, 16'h00F0, 16'h000F, 16'h00E1, 2'b01, 3'd4, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    step(1'b1, 16'h00F0, 16'h000F, 16'h00E1, 2'b01, 3'd4, 1'b1);
    chk("pop_from_full_count", 32'(count), 32'd3);
    step(1'b1, 16'h00F0, 16'h000F, 16'h00E1, 2'b01, 3'd4, 1'b1);
    chk("pushpop_count", 32'(count), 32'd3);
    for (int t = 0; t < 4; t++) idle(1'b1);
    chk("order_len", 32'(popLog.size()), 32'd5);
    for (int t = 0; t < 5 && t < popLog.size(); t++) chk("order_tag", 32'(popLog[t]), 32'(t));

    // Randomized traffic with random backpressure.
    accepted = 0;
    cyc = 0;
    while (accepted < 200 && cyc < 5000) begin
      iv = ($urandom_range(0, 3) != 0);
      wr = ($urandom_range(0, 1) != 0);
      bn = 2'($urandom_range(0, 3));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      r  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : laneSub(a, b, bn);
      step(iv, a, b, r, bn, 3'($urandom), wr);
      cyc++;
    end
    chk("rand_accepted", 32'(accepted), 32'd200);
    chk("rand_wraps", 32'(accepted / DEPTH >= 40), 32'd1);
    for (int t = 0; t < DEPTH + 2; t++) idle(1'b1);
    chk("drained", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
